// File: rtl/tof_result_collector.sv
// Collects results from NB_OF_SENSORS ToF channels into per-channel capture
// registers, arbitrates them round-robin and queues {idx, zone, distance} records.
module tof_result_collector #(
  parameter int NB_OF_SENSORS = 8,
  parameter int IDX_W         = 3,
  parameter int ZONE_W        = 6,
  parameter int DIST_W        = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_W         = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NB_OF_SENSORS-1:0]          data_ready,
  input  logic [NB_OF_SENSORS*DIST_W-1:0]   distance_in,
  input  logic [NB_OF_SENSORS*ZONE_W-1:0]   zone_in,
  input  logic [NB_OF_SENSORS-1:0]          channel_enable,
  input  logic                              out_ready,
  input  logic                              clear_overrun,
  output logic                              out_valid,
  output logic [IDX_W+ZONE_W+DIST_W-1:0]    out_data,
  output logic [CNT_W-1:0]                  fifo_level,
  output logic [NB_OF_SENSORS-1:0]          pending,
  output logic [NB_OF_SENSORS-1:0]          overrun
);

  localparam int REC_W = IDX_W + ZONE_W + DIST_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Handshake: a record transfers on any rising edge where out_valid & out_ready;
  // out_data holds the head record and does not change while it is stalled.

  logic [DIST_W-1:0]        cap_dist [NB_OF_SENSORS];
  logic [ZONE_W-1:0]        cap_zone [NB_OF_SENSORS];
  logic [NB_OF_SENSORS-1:0] strobe;
  logic [NB_OF_SENSORS-1:0] req;
  logic [NB_OF_SENSORS-1:0] grant_vec;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic [IDX_W-1:0]         rr_ptr;

  logic [REC_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         level;
  logic                     fifo_full;
  logic                     push;
  logic                     pop;
  logic [REC_W-1:0]         push_rec;

  assign strobe    = data_ready & channel_enable;
  assign fifo_full = (level == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle never frees a slot for a grant.
  assign req       = fifo_full ? '0 : pending;

  always_comb begin : arbiter
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < NB_OF_SENSORS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NB_OF_SENSORS) j = j - NB_OF_SENSORS;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_valid) grant_vec[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NB_OF_SENSORS; i++) begin
        cap_dist[i] <= '0;
        cap_zone[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_OF_SENSORS; i++) begin
        // A granted channel forwards its old record, so a new strobe may reload it.
        if (strobe[i] && (!pending[i] || grant_vec[i])) begin
          cap_dist[i] <= distance_in[i*DIST_W +: DIST_W];
          cap_zone[i] <= zone_in[i*ZONE_W +: ZONE_W];
          pending[i]  <= 1'b1;
        end else if (grant_vec[i]) begin
          pending[i]  <= 1'b0;
        end
        if (strobe[i] && pending[i] && !grant_vec[i]) overrun[i] <= 1'b1;
        else if (clear_overrun)                       overrun[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IDX_W'(NB_OF_SENSORS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  assign push     = grant_valid;
  assign pop      = out_valid && out_ready;
  assign push_rec = {grant_idx, cap_zone[grant_idx], cap_dist[grant_idx]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: it is only visible through a non-empty level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_tof_result_collector.sv
// Directed bench for tof_result_collector: hand-computed records are queued in
// exp_q and compared in order as the consumer drains the FIFO.
module tb_tof_result_collector;

  localparam int NB     = 8;
  localparam int IDX_W  = 3;
  localparam int ZONE_W = 6;
  localparam int DIST_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int REC_W  = IDX_W + ZONE_W + DIST_W;

  logic                   clk;
  logic                   reset;
  logic [NB-1:0]          data_ready;
  logic [NB*DIST_W-1:0]   distance_in;
  logic [NB*ZONE_W-1:0]   zone_in;
  logic [NB-1:0]          channel_enable;
  logic                   out_ready;
  logic                   clear_overrun;
  logic                   out_valid;
  logic [REC_W-1:0]       out_data;
  logic [CNT_W-1:0]       fifo_level;
  logic [NB-1:0]          pending;
  logic [NB-1:0]          overrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [REC_W-1:0] exp_q[$];

  tof_result_collector #(
    .NB_OF_SENSORS(NB), .IDX_W(IDX_W), .ZONE_W(ZONE_W),
    .DIST_W(DIST_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready),
    .distance_in(distance_in), .zone_in(zone_in),
    .channel_enable(channel_enable), .out_ready(out_ready),
    .clear_overrun(clear_overrun), .out_valid(out_valid),
    .out_data(out_data), .fifo_level(fifo_level),
    .pending(pending), .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input logic [2:0] i, input logic [5:0] z,
                                           input logic [15:0] d);
    return {i, z, d};
  endfunction

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ch(input int i, input logic [15:0] d, input logic [5:0] z);
    distance_in[i*DIST_W +: DIST_W] = d;
    zone_in[i*ZONE_W +: ZONE_W]     = z;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_ready     = '0;
    clear_overrun  = 1'b0;
    out_ready      = 1'b0;
    channel_enable = '1;
    distance_in    = '0;
    zone_in        = '0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // scoreboard: consumer always ready, each valid head must match the queue front
  task automatic drain(input string tag);
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 64) begin
      if (out_valid) chk(tag, out_data, exp_q.pop_front());
      tick();
      guard++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_valid"}, out_valid, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);

    // single strobe, two-cycle latency
    set_ch(5, 16'h01F4, 6'h0A);
    data_ready = 8'h20;
    out_ready  = 1'b1;
    tick();
    data_ready = '0;
    chk("t1_pending", pending, 8'h20);
    chk("t1_valid_early", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, rec(3'd5, 6'h0A, 16'h01F4));
    chk("t1_level", fifo_level, 1);
    chk("t1_pending_clr", pending, 0);
    tick();
    chk("t1_popped_valid", out_valid, 0);
    chk("t1_popped_level", fifo_level, 0);

    // all channels at once, round-robin order from pointer 0
    do_reset();
    for (int i = 0; i < NB; i++) set_ch(i, 16'h0100 + 16'(i), 6'(i + 1));
    data_ready = 8'hFF;
    out_ready  = 1'b1;
    tick();
    data_ready = '0;
    chk("t2_pending", pending, 8'hFF);
    for (int i = 0; i < NB; i++) exp_q.push_back(rec(3'(i), 6'(i + 1), 16'h0100 + 16'(i)));
    drain("t2_order");
    chk("t2_overrun", overrun, 0);
    // pointer wrapped back to 0: ch0 must beat ch7
    set_ch(0, 16'h0200, 6'h20);
    set_ch(7, 16'h0207, 6'h27);
    data_ready = 8'h81;
    tick();
    data_ready = '0;
    exp_q.push_back(rec(3'd0, 6'h20, 16'h0200));
    exp_q.push_back(rec(3'd7, 6'h27, 16'h0207));
    drain("t2_ptr0");

    // back-pressure: FIFO fills, ch2 overruns
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      set_ch(2, 16'(k), 6'(k));
      data_ready = 8'h04;
      tick();
      data_ready = '0;
      if (k == 17) begin
        chk("t3_ovr_at17", overrun, 0);
        chk("t3_level_at17", fifo_level, DEPTH);
        chk("t3_pend_at17", pending, 8'h04);
      end
      if (k == 18) chk("t3_ovr_at18", overrun, 8'h04);
      tick();
    end
    chk("t3_level_full", fifo_level, DEPTH);
    chk("t3_pending", pending, 8'h04);
    chk("t3_overrun", overrun, 8'h04);
    set_ch(2, 16'd21, 6'd21);
    data_ready    = 8'h04;
    clear_overrun = 1'b1;
    tick();
    data_ready    = '0;
    clear_overrun = 1'b0;
    chk("t3_set_wins", overrun, 8'h04);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t3_cleared", overrun, 0);
    for (int k = 1; k <= 17; k++) exp_q.push_back(rec(3'd2, 6'(k), 16'(k)));
    drain("t3_drain");

    // strobe in the cycle the channel is granted
    do_reset();
    set_ch(3, 16'hAAAA, 6'h11);
    data_ready = 8'h08;
    tick();
    set_ch(3, 16'hBBBB, 6'h22);
    tick();
    data_ready = '0;
    chk("t4_pending", pending, 8'h08);
    chk("t4_overrun", overrun, 0);
    chk("t4_head", out_data, rec(3'd3, 6'h11, 16'hAAAA));
    exp_q.push_back(rec(3'd3, 6'h11, 16'hAAAA));
    exp_q.push_back(rec(3'd3, 6'h22, 16'hBBBB));
    drain("t4_drain");

    // disabled channel is ignored
    do_reset();
    channel_enable = 8'hFE;
    set_ch(0, 16'h0AA0, 6'h01);
    set_ch(1, 16'h0BB1, 6'h02);
    data_ready = 8'h03;
    tick();
    data_ready = '0;
    chk("t5_pending", pending, 8'h02);
    exp_q.push_back(rec(3'd1, 6'h02, 16'h0BB1));
    drain("t5_drain");
    chk("t5_pending_end", pending, 0);
    channel_enable = 8'hFF;

    // reset in the middle of traffic
    do_reset();
    for (int i = 1; i <= 6; i++) set_ch(i, 16'h0600 + 16'(i), 6'h30 + 6'(i));
    data_ready = 8'h7E;
    tick();
    data_ready = '0;
    repeat (5) tick();
    set_ch(0, 16'h0E00, 6'h0E);
    set_ch(7, 16'h0E07, 6'h0F);
    data_ready = 8'h81;
    tick();
    data_ready = '0;
    chk("t6_level_pre", fifo_level, 6);
    chk("t6_pending_pre", pending, 8'h81);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_level", fifo_level, 0);
    chk("t6_async_pending", pending, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_post_valid", out_valid, 0);
    set_ch(0, 16'h0D00, 6'h1D);
    set_ch(7, 16'h0D07, 6'h17);
    data_ready = 8'h81;
    tick();
    data_ready = '0;
    exp_q.push_back(rec(3'd0, 6'h1D, 16'h0D00));
    exp_q.push_back(rec(3'd7, 6'h17, 16'h0D07));
    drain("t6_drain");

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
